// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fetch_pkg
// Purpose : Shared constants and types for the instruction-fetch stage.
//           NOP_INSTR        - bubble word loaded into IF/ID on a squash
//           DEFAULT_INC      - default sequential PC increment (bytes)
//           DEFAULT_RESET_PC - default PC after reset
//           redir_state_t    - redirect FSM state encoding {RUN, PEND}
// Revision: 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_INC      = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // RUN : no redirect outstanding
    // PEND: a redirect arrived during a stall and is held in the pending target
    typedef enum logic [0:0] {
        RUN  = 1'b0,
        PEND = 1'b1
    } redir_state_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_pc_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : fetch_pc_unit_if
// Purpose : Bundle of the fetch-stage control, instruction-memory and IF/ID
//           signals.
//           slave  - the fetch unit (drives imem_addr, ifid_*, fetch_count)
//           master - the environment (drives stall, br_*, imem_data)
// Ports   : stall, br_taken, br_target[N], imem_addr[N], imem_data[32],
//           ifid_instr[32], ifid_pc_plus4[N], ifid_valid, fetch_count[32]
// Revision: 1.0 - initial release
// ============================================================================
interface fetch_pc_unit_if #(
    parameter int N = 32
);
    logic          stall;
    logic          br_taken;
    logic [N-1:0]  br_target;
    logic [N-1:0]  imem_addr;
    logic [31:0]   imem_data;
    logic [31:0]   ifid_instr;
    logic [N-1:0]  ifid_pc_plus4;
    logic          ifid_valid;
    logic [31:0]   fetch_count;

    modport master (
        output stall, br_taken, br_target, imem_data,
        input  imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, fetch_count
    );

    modport slave (
        input  stall, br_taken, br_target, imem_data,
        output imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, fetch_count
    );
endinterface : fetch_pc_unit_if
`default_nettype wire

// File: rtl/mux2.sv
`default_nettype none
// ============================================================================
// Module  : mux2
// Purpose : Generic 2-to-1 N-bit multiplexer cell.
// Ports   : i_sel (0 selects i_d0, 1 selects i_d1), i_d0[N], i_d1[N], o_y[N]
// Revision: 1.0 - initial release
// ============================================================================
module mux2 #(
    parameter int N = 32
) (
    input  wire logic         i_sel,
    input  wire logic [N-1:0] i_d0,
    input  wire logic [N-1:0] i_d1,
    output logic      [N-1:0] o_y
);
    assign o_y = i_sel ? i_d1 : i_d0;
endmodule : mux2
`default_nettype wire

// File: rtl/pc_redirect_ctl.sv
`default_nettype none
// ============================================================================
// Module  : pc_redirect_ctl
// Purpose : Redirect bookkeeping for the fetch stage. A branch redirect that
//           arrives while the stage is stalled is buffered (newest wins) and
//           replayed on the first unstalled cycle.
// Ports   : clk, reset            - clock, synchronous active-high reset
//           i_stall               - fetch stall
//           i_br_taken/i_br_target- redirect request from ID
//           o_redir_active        - a redirect is requested this cycle
//           o_redir_target[N]     - the address to redirect to
// Revision: 1.0 - initial release
// ============================================================================
module pc_redirect_ctl
    import fetch_pkg::*;
#(
    parameter int N = 32
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic         i_stall,
    input  wire logic         i_br_taken,
    input  wire logic [N-1:0] i_br_target,
    output logic              o_redir_active,
    output logic      [N-1:0] o_redir_target
);
    redir_state_t r_state;
    logic [N-1:0] r_pend_target;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= RUN;
            r_pend_target <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    // Unstalled redirects are applied directly, never buffered
                    if (i_stall && i_br_taken) begin
                        r_state       <= PEND;
                        r_pend_target <= i_br_target;
                    end
                end
                PEND: begin
                    if (i_stall) begin
                        if (i_br_taken) begin
                            r_pend_target <= i_br_target;
                        end
                    end else begin
                        r_state <= RUN;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

    // Combinational on purpose: a live br_taken must steer the PC in the same
    // cycle, and it outranks any buffered target.
    assign o_redir_active = i_br_taken || (r_state == PEND);
    assign o_redir_target = i_br_taken ? i_br_target : r_pend_target;

endmodule : pc_redirect_ctl
`default_nettype wire

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module  : fetch_pc_unit
// Purpose : Instruction-fetch stage. Holds the PC, drives the instruction
//           memory address, selects the next PC (sequential or redirect) and
//           registers the fetched word into the IF/ID latch.
// Macro   : BRANCH_DELAY_SLOT_EN - when defined, the instruction in IF at the
//           moment a redirect is applied is kept as a delay slot; otherwise
//           it is squashed to a NOP bubble.
// Ports   : clk, reset - clock, synchronous active-high reset
//           bus        - fetch_pc_unit_if.slave (control, imem, IF/ID)
// Revision: 1.0 - initial release
// ============================================================================
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter int           N        = 32,
    parameter logic [N-1:0] RESET_PC = N'(DEFAULT_RESET_PC),
    parameter logic [N-1:0] INC      = N'(DEFAULT_INC)
) (
    input  wire logic       clk,
    input  wire logic       reset,
    fetch_pc_unit_if.slave  bus
);
`ifdef BRANCH_DELAY_SLOT_EN
    localparam bit C_DELAY_SLOT = 1'b1;
`else
    localparam bit C_DELAY_SLOT = 1'b0;
`endif

    logic [N-1:0] r_pc;
    logic [31:0]  r_ifid_instr;
    logic [N-1:0] r_ifid_pc_plus4;
    logic         r_ifid_valid;
    logic [31:0]  r_fetch_count;

    logic [N-1:0] w_pc_plus_inc;
    logic [N-1:0] w_next_pc;
    logic         w_redir_active;
    logic [N-1:0] w_redir_target;
    logic         w_redir_apply;
    logic         w_squash;

    pc_redirect_ctl #(
        .N (N)
    ) u_redirect (
        .clk            (clk),
        .reset          (reset),
        .i_stall        (bus.stall),
        .i_br_taken     (bus.br_taken),
        .i_br_target    (bus.br_target),
        .o_redir_active (w_redir_active),
        .o_redir_target (w_redir_target)
    );

    // Modulo 2^N: wraps silently past all-ones
    assign w_pc_plus_inc = r_pc + INC;

    mux2 #(
        .N (N)
    ) u_next_pc_mux (
        .i_sel (w_redir_active),
        .i_d0  (w_pc_plus_inc),
        .i_d1  (w_redir_target),
        .o_y   (w_next_pc)
    );

    // A redirect only takes effect on an unstalled edge; the word in IF at
    // that edge is the one that may be squashed.
    assign w_redir_apply = !bus.stall && w_redir_active;
    assign w_squash      = w_redir_apply && !C_DELAY_SLOT;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc            <= RESET_PC;
            r_ifid_instr    <= NOP_INSTR;
            r_ifid_pc_plus4 <= '0;
            r_ifid_valid    <= 1'b0;
            r_fetch_count   <= '0;
        end else if (!bus.stall) begin
            r_pc            <= w_next_pc;
            r_ifid_pc_plus4 <= w_pc_plus_inc;
            if (w_squash) begin
                r_ifid_instr <= NOP_INSTR;
                r_ifid_valid <= 1'b0;
            end else begin
                r_ifid_instr  <= bus.imem_data;
                r_ifid_valid  <= 1'b1;
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    assign bus.imem_addr     = r_pc;
    assign bus.ifid_instr    = r_ifid_instr;
    assign bus.ifid_pc_plus4 = r_ifid_pc_plus4;
    assign bus.ifid_valid    = r_ifid_valid;
    assign bus.fetch_count   = r_fetch_count;

endmodule : fetch_pc_unit
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_fetch_pc_unit
// Purpose : Directed self-checking bench for fetch_pc_unit. Instruction
//           memory is modelled as data = addr ^ 32'hDEADBEEF.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fetch_pc_unit;
`ifdef BRANCH_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [31:0] exp_cnt;

    fetch_pc_unit_if #(.N(32)) bus ();

    fetch_pc_unit #(.N(32), .RESET_PC(32'h0), .INC(32'd4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hDEADBEEF;
    endfunction

    assign bus.imem_data = mem(bus.imem_addr);

    // Squashed-or-delay-slot word for a redirect applied while PC = a
    function automatic logic [31:0] slot_instr(input logic [31:0] a);
        return DS ? mem(a) : 32'h0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.stall = 1'b0; bus.br_taken = 1'b0; bus.br_target = '0;
        tick(); tick();
        n_cmp++; if (bus.imem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr got %h want %h", bus.imem_addr, 32'h0); end
        n_cmp++; if (bus.ifid_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", bus.ifid_valid); end
        n_cmp++; if (bus.ifid_instr !== 32'h0) begin n_bad++; $display("FAIL reset_instr got %h want 0", bus.ifid_instr); end
        n_cmp++; if (bus.ifid_pc_plus4 !== 32'h0) begin n_bad++; $display("FAIL reset_pp4 got %h want 0", bus.ifid_pc_plus4); end
        n_cmp++; if (bus.fetch_count !== 32'h0) begin n_bad++; $display("FAIL reset_count got %0d want 0", bus.fetch_count); end
        reset = 1'b0;
    endtask

    task automatic test_free_run();
        tick();
        n_cmp++; if (bus.imem_addr !== 32'h4) begin n_bad++; $display("FAIL run1_addr got %h want 4", bus.imem_addr); end
        n_cmp++; if (bus.ifid_valid !== 1'b1) begin n_bad++; $display("FAIL run1_valid got %b want 1", bus.ifid_valid); end
        n_cmp++; if (bus.ifid_instr !== mem(32'h0)) begin n_bad++; $display("FAIL run1_instr got %h want %h", bus.ifid_instr, mem(32'h0)); end
        n_cmp++; if (bus.ifid_pc_plus4 !== 32'h4) begin n_bad++; $display("FAIL run1_pp4 got %h want 4", bus.ifid_pc_plus4); end
        tick();
        n_cmp++; if (bus.imem_addr !== 32'h8) begin n_bad++; $display("FAIL run2_addr got %h want 8", bus.imem_addr); end
        n_cmp++; if (bus.fetch_count !== 32'd2) begin n_bad++; $display("FAIL run2_count got %0d want 2", bus.fetch_count); end
        exp_cnt = 32'd2;
    endtask

    task automatic test_branch();
        tick(); tick();
        exp_cnt = 32'd4;
        n_cmp++; if (bus.imem_addr !== 32'h10) begin n_bad++; $display("FAIL br_pre_addr got %h want 10", bus.imem_addr); end
        bus.br_taken = 1'b1; bus.br_target = 32'h100;
        tick();
        bus.br_taken = 1'b0;
        exp_cnt += 32'(DS);
        n_cmp++; if (bus.imem_addr !== 32'h100) begin n_bad++; $display("FAIL br_addr got %h want 100", bus.imem_addr); end
        n_cmp++; if (bus.ifid_valid !== DS) begin n_bad++; $display("FAIL br_valid got %b want %b", bus.ifid_valid, DS); end
        n_cmp++; if (bus.ifid_instr !== slot_instr(32'h10)) begin n_bad++; $display("FAIL br_instr got %h want %h", bus.ifid_instr, slot_instr(32'h10)); end
        n_cmp++; if (bus.ifid_pc_plus4 !== 32'h14) begin n_bad++; $display("FAIL br_pp4 got %h want 14", bus.ifid_pc_plus4); end
        n_cmp++; if (bus.fetch_count !== exp_cnt) begin n_bad++; $display("FAIL br_count got %0d want %0d", bus.fetch_count, exp_cnt); end
        tick();
        exp_cnt += 32'd1;
        n_cmp++; if (bus.imem_addr !== 32'h104) begin n_bad++; $display("FAIL br_next_addr got %h want 104", bus.imem_addr); end
        n_cmp++; if (bus.ifid_instr !== mem(32'h100)) begin n_bad++; $display("FAIL br_next_instr got %h want %h", bus.ifid_instr, mem(32'h100)); end
        n_cmp++; if (bus.fetch_count !== exp_cnt) begin n_bad++; $display("FAIL br_next_count got %0d want %0d", bus.fetch_count, exp_cnt); end
    endtask

    task automatic test_stall();
        bus.br_taken = 1'b1; bus.br_target = 32'h20;
        tick();
        bus.br_taken = 1'b0;
        exp_cnt += 32'(DS);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (bus.imem_addr !== 32'h20) begin n_bad++; $display("FAIL stall%0d_addr got %h want 20", i, bus.imem_addr); end
            n_cmp++; if (bus.ifid_instr !== slot_instr(32'h104)) begin n_bad++; $display("FAIL stall%0d_instr got %h want %h", i, bus.ifid_instr, slot_instr(32'h104)); end
            n_cmp++; if (bus.ifid_valid !== DS) begin n_bad++; $display("FAIL stall%0d_valid got %b want %b", i, bus.ifid_valid, DS); end
            n_cmp++; if (bus.ifid_pc_plus4 !== 32'h108) begin n_bad++; $display("FAIL stall%0d_pp4 got %h want 108", i, bus.ifid_pc_plus4); end
            n_cmp++; if (bus.fetch_count !== exp_cnt) begin n_bad++; $display("FAIL stall%0d_count got %0d want %0d", i, bus.fetch_count, exp_cnt); end
        end
        bus.stall = 1'b0;
        tick();
        exp_cnt += 32'd1;
        n_cmp++; if (bus.imem_addr !== 32'h24) begin n_bad++; $display("FAIL unstall_addr got %h want 24", bus.imem_addr); end
        n_cmp++; if (bus.ifid_instr !== mem(32'h20)) begin n_bad++; $display("FAIL unstall_instr got %h want %h", bus.ifid_instr, mem(32'h20)); end
        n_cmp++; if (bus.ifid_valid !== 1'b1) begin n_bad++; $display("FAIL unstall_valid got %b want 1", bus.ifid_valid); end
        n_cmp++; if (bus.fetch_count !== exp_cnt) begin n_bad++; $display("FAIL unstall_count got %0d want %0d", bus.fetch_count, exp_cnt); end
    endtask

    task automatic test_pending_redirect();
        bus.stall = 1'b1; bus.br_taken = 1'b1; bus.br_target = 32'h200;
        tick();
        n_cmp++; if (bus.imem_addr !== 32'h24) begin n_bad++; $display("FAIL pend1_addr got %h want 24", bus.imem_addr); end
        bus.br_target = 32'h300;
        tick();
        n_cmp++; if (bus.imem_addr !== 32'h24) begin n_bad++; $display("FAIL pend2_addr got %h want 24", bus.imem_addr); end
        bus.br_taken = 1'b0;
        tick();
        n_cmp++; if (bus.imem_addr !== 32'h24) begin n_bad++; $display("FAIL pend3_addr got %h want 24", bus.imem_addr); end
        n_cmp++; if (bus.fetch_count !== exp_cnt) begin n_bad++; $display("FAIL pend3_count got %0d want %0d", bus.fetch_count, exp_cnt); end
        bus.stall = 1'b0;
        tick();
        exp_cnt += 32'(DS);
        n_cmp++; if (bus.imem_addr !== 32'h300) begin n_bad++; $display("FAIL pend_rel_addr got %h want 300", bus.imem_addr); end
        n_cmp++; if (bus.ifid_valid !== DS) begin n_bad++; $display("FAIL pend_rel_valid got %b want %b", bus.ifid_valid, DS); end
        n_cmp++; if (bus.ifid_pc_plus4 !== 32'h28) begin n_bad++; $display("FAIL pend_rel_pp4 got %h want 28", bus.ifid_pc_plus4); end
        tick();
        exp_cnt += 32'd1;
        n_cmp++; if (bus.imem_addr !== 32'h304) begin n_bad++; $display("FAIL pend_after_addr got %h want 304", bus.imem_addr); end
        n_cmp++; if (bus.ifid_instr !== mem(32'h300)) begin n_bad++; $display("FAIL pend_after_instr got %h want %h", bus.ifid_instr, mem(32'h300)); end
        n_cmp++; if (bus.fetch_count !== exp_cnt) begin n_bad++; $display("FAIL pend_after_count got %0d want %0d", bus.fetch_count, exp_cnt); end
    endtask

    task automatic test_live_beats_pending();
        bus.stall = 1'b1; bus.br_taken = 1'b1; bus.br_target = 32'h600;
        tick();
        bus.stall = 1'b0; bus.br_target = 32'h700;
        tick();
        bus.br_taken = 1'b0;
        exp_cnt += 32'(DS);
        n_cmp++; if (bus.imem_addr !== 32'h700) begin n_bad++; $display("FAIL live_addr got %h want 700", bus.imem_addr); end
        tick();
        exp_cnt += 32'd1;
        n_cmp++; if (bus.imem_addr !== 32'h704) begin n_bad++; $display("FAIL live_next_addr got %h want 704", bus.imem_addr); end
        n_cmp++; if (bus.fetch_count !== exp_cnt) begin n_bad++; $display("FAIL live_count got %0d want %0d", bus.fetch_count, exp_cnt); end
    endtask

    task automatic test_wrap();
        bus.br_taken = 1'b1; bus.br_target = 32'hFFFF_FFFC;
        tick();
        bus.br_taken = 1'b0;
        n_cmp++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_pre_addr got %h want fffffffc", bus.imem_addr); end
        tick();
        n_cmp++; if (bus.imem_addr !== 32'h0) begin n_bad++; $display("FAIL wrap_addr got %h want 0", bus.imem_addr); end
        n_cmp++; if (bus.ifid_pc_plus4 !== 32'h0) begin n_bad++; $display("FAIL wrap_pp4 got %h want 0", bus.ifid_pc_plus4); end
        n_cmp++; if (bus.ifid_instr !== mem(32'hFFFF_FFFC)) begin n_bad++; $display("FAIL wrap_instr got %h want %h", bus.ifid_instr, mem(32'hFFFF_FFFC)); end
        n_cmp++; if (bus.ifid_valid !== 1'b1) begin n_bad++; $display("FAIL wrap_valid got %b want 1", bus.ifid_valid); end
    endtask

    task automatic test_reset_in_pend();
        tick();
        n_cmp++; if (bus.imem_addr !== 32'h4) begin n_bad++; $display("FAIL rp_pre_addr got %h want 4", bus.imem_addr); end
        bus.stall = 1'b1; bus.br_taken = 1'b1; bus.br_target = 32'h500;
        tick();
        reset = 1'b1; bus.br_taken = 1'b0;
        tick();
        n_cmp++; if (bus.imem_addr !== 32'h0) begin n_bad++; $display("FAIL rp_addr got %h want 0", bus.imem_addr); end
        n_cmp++; if (bus.ifid_valid !== 1'b0) begin n_bad++; $display("FAIL rp_valid got %b want 0", bus.ifid_valid); end
        n_cmp++; if (bus.fetch_count !== 32'h0) begin n_bad++; $display("FAIL rp_count got %0d want 0", bus.fetch_count); end
        n_cmp++; if (bus.ifid_instr !== 32'h0) begin n_bad++; $display("FAIL rp_instr got %h want 0", bus.ifid_instr); end
        reset = 1'b0; bus.stall = 1'b0;
        tick();
        n_cmp++; if (bus.imem_addr !== 32'h4) begin n_bad++; $display("FAIL rp_after_addr got %h want 4", bus.imem_addr); end
        n_cmp++; if (bus.ifid_valid !== 1'b1) begin n_bad++; $display("FAIL rp_after_valid got %b want 1", bus.ifid_valid); end
        n_cmp++; if (bus.fetch_count !== 32'd1) begin n_bad++; $display("FAIL rp_after_count got %0d want 1", bus.fetch_count); end
        tick();
        n_cmp++; if (bus.imem_addr !== 32'h8) begin n_bad++; $display("FAIL rp_after2_addr got %h want 8", bus.imem_addr); end
    endtask

    initial begin
        exp_cnt = '0;
        test_reset();
        test_free_run();
        test_branch();
        test_stall();
        test_pending_redirect();
        test_live_beats_pending();
        test_wrap();
        test_reset_in_pend();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule : tb_fetch_pc_unit
`default_nettype wire
